// File: rtl/bus_term_pkg.sv
// Shared types and helpers for the bus terminal endpoint.
// Optional stats outputs are enabled by defining BUS_TERM_STATS_EN.
package bus_term_pkg;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned PKT_MAX_W = 256;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  typedef logic [15:0] stat_cnt_t;

  // Destination ID sits in the top ID_W bits of a pkt_w-bit packet.
  function automatic logic [ID_W-1:0] get_dst(input logic [PKT_MAX_W-1:0] pkt,
                                              input int unsigned pkt_w);
    logic [PKT_MAX_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/bus_term_endpoint_if.sv
// Bus-side and host-side signal bundle of the terminal endpoint.
// Stats counters exist only when BUS_TERM_STATS_EN is defined.
interface bus_term_endpoint_if #(
  parameter int unsigned pckg_sz = 16
) ();

  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               tx_wr;
  logic [pckg_sz-1:0] tx_data;
  logic               tx_full;
  logic               rx_rd;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_empty;
  logic               rx_ovf;
  logic               proto_err;
  logic               clr_flags;
`ifdef BUS_TERM_STATS_EN
  bus_term_pkg::stat_cnt_t tx_sent_cnt;
  bus_term_pkg::stat_cnt_t rx_acc_cnt;
  bus_term_pkg::stat_cnt_t rx_drop_cnt;
`endif

  modport slave (
`ifdef BUS_TERM_STATS_EN
    output tx_sent_cnt, rx_acc_cnt, rx_drop_cnt,
`endif
    output pndng, D_pop, tx_full, rx_data, rx_empty, rx_ovf, proto_err,
    input  pop, push, D_push, tx_wr, tx_data, rx_rd, clr_flags
  );

  modport master (
`ifdef BUS_TERM_STATS_EN
    input  tx_sent_cnt, rx_acc_cnt, rx_drop_cnt,
`endif
    input  pndng, D_pop, tx_full, rx_data, rx_empty, rx_ovf, proto_err,
    output pop, push, D_push, tx_wr, tx_data, rx_rd, clr_flags
  );

endinterface

// File: rtl/term_sync_fifo.sv
// Show-ahead synchronous FIFO with simultaneous read/write; head reads 0 when empty.
module term_sync_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [Width-1:0] wdata,
  input  logic            rd,
  output logic [Width-1:0] rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_wr, do_rd;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem[rd_ptr_q];

  // A write into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bus_term_endpoint.sv
// Device-side bus terminal: TX FIFO drained by the bus, ID-filtered RX FIFO, sticky flags.
// Define BUS_TERM_STATS_EN to add saturating tx_sent/rx_acc/rx_drop counters.
module bus_term_endpoint
  import bus_term_pkg::*;
#(
  parameter int unsigned     pckg_sz   = 16,
  parameter int unsigned     depth     = 8,
  parameter logic [ID_W-1:0] term_id   = 8'h00,
  parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
  input logic            clk,
  input logic            reset,
  bus_term_endpoint_if.slave bus
);

  localparam int unsigned CntW = $clog2(depth) + 1;

  logic [CntW-1:0] tx_count, rx_count;
  logic            tx_empty, rx_empty_int, rx_full;
  logic            id_match, rx_wr, rx_rd_ok, ovf_set, perr_set;
  logic            rx_ovf_q, rx_ovf_d, proto_err_q, proto_err_d;
  logic [ID_W-1:0] dst;

  term_sync_fifo #(
    .Width(pckg_sz),
    .Depth(depth)
  ) u_tx_fifo (
    .clk  (clk),
    .reset(reset),
    .wr   (bus.tx_wr),
    .wdata(bus.tx_data),
    .rd   (bus.pop),
    .rdata(bus.D_pop),
    .full (bus.tx_full),
    .empty(tx_empty),
    .count(tx_count)
  );

  term_sync_fifo #(
    .Width(pckg_sz),
    .Depth(depth)
  ) u_rx_fifo (
    .clk  (clk),
    .reset(reset),
    .wr   (rx_wr),
    .wdata(bus.D_push),
    .rd   (bus.rx_rd),
    .rdata(bus.rx_data),
    .full (rx_full),
    .empty(rx_empty_int),
    .count(rx_count)
  );

  assign bus.pndng    = (tx_count != '0);
  assign bus.rx_empty = (rx_count == '0);

  assign dst      = get_dst(PKT_MAX_W'(bus.D_push), pckg_sz);
  assign id_match = (dst == term_id) || (dst == broadcast);
  assign rx_wr    = bus.push & id_match;
  assign rx_rd_ok = bus.rx_rd & ~rx_empty_int;
  assign ovf_set  = rx_wr & rx_full & ~rx_rd_ok;
  assign perr_set = bus.pop & tx_empty;

  // Set events override a same-cycle clear.
  always_comb begin
    rx_ovf_d    = (rx_ovf_q & ~bus.clr_flags) | ovf_set;
    proto_err_d = (proto_err_q & ~bus.clr_flags) | perr_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ovf_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      rx_ovf_q    <= rx_ovf_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.rx_ovf    = rx_ovf_q;
  assign bus.proto_err = proto_err_q;

`ifdef BUS_TERM_STATS_EN
  stat_cnt_t tx_sent_q, tx_sent_d, rx_acc_q, rx_acc_d, rx_drop_q, rx_drop_d;
  logic      tx_sent_inc, rx_acc_inc, rx_drop_inc;

  assign tx_sent_inc = bus.pop & ~tx_empty;
  assign rx_acc_inc  = rx_wr & (~rx_full | rx_rd_ok);
  assign rx_drop_inc = bus.push & (~id_match | ovf_set);

  always_comb begin
    tx_sent_d = tx_sent_q;
    rx_acc_d  = rx_acc_q;
    rx_drop_d = rx_drop_q;
    if (bus.clr_flags) begin
      tx_sent_d = '0;
      rx_acc_d  = '0;
      rx_drop_d = '0;
    end else begin
      if (tx_sent_inc && tx_sent_q != '1) tx_sent_d = tx_sent_q + 16'd1;
      if (rx_acc_inc && rx_acc_q != '1)   rx_acc_d  = rx_acc_q + 16'd1;
      if (rx_drop_inc && rx_drop_q != '1) rx_drop_d = rx_drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_sent_q <= '0;
      rx_acc_q  <= '0;
      rx_drop_q <= '0;
    end else begin
      tx_sent_q <= tx_sent_d;
      rx_acc_q  <= rx_acc_d;
      rx_drop_q <= rx_drop_d;
    end
  end

  assign bus.tx_sent_cnt = tx_sent_q;
  assign bus.rx_acc_cnt  = rx_acc_q;
  assign bus.rx_drop_cnt = rx_drop_q;
`endif

endmodule
